// File: rtl/mem_responder_if.sv
// Request/response bus between a cache (master) and the memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory model with fixed request latency, one-cycle ready pulse, sticky error and op counters.
// Define MEM_RAND_LATENCY_EN to add 0..3 LFSR-chosen extra wait cycles per request.
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_responder_if.slave    mem,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q;
  logic [8:0]              cnt_q;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic [31:0]             rd_cnt_q;
  logic [31:0]             wr_cnt_q;
  logic                    op_wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   ram_q [0:(1<<DEPTH_LOG2)-1];

  logic                    req;
  logic                    accept;
  logic [DEPTH_LOG2-1:0]   idx_d;
  logic [8:0]              lat_m1;
  logic                    enter_resp;
  logic                    resp_wr;
  logic [DEPTH_LOG2-1:0]   resp_idx;
  logic                    unused_addr_bits;

  assign req    = mem.mem_rd | mem.mem_wr;
  assign accept = (state_q == IDLE) && req;
  assign idx_d  = mem.mem_addr[DEPTH_LOG2+1:2];
  // High address bits alias silently onto the array.
  assign unused_addr_bits = ^mem.mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

`ifdef MEM_RAND_LATENCY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign lat_m1 = 9'(LATENCY - 1) + {7'd0, lfsr_q[1:0]};
`else
  assign lat_m1 = 9'(LATENCY - 1);
`endif

  // A response starts either straight from acceptance (latency 1) or when the wait count runs out.
  always_comb begin
    enter_resp = 1'b0;
    resp_wr    = op_wr_q;
    resp_idx   = idx_q;
    if (state_q == IDLE) begin
      enter_resp = accept && (lat_m1 == 9'd0);
      resp_wr    = mem.mem_wr;
      resp_idx   = idx_d;
    end else if (state_q == WAIT) begin
      enter_resp = (cnt_q == 9'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if ((mem.mem_rd & mem.mem_wr) | (|mem.mem_addr[1:0])) err_q <= 1'b1;
            state_q <= (lat_m1 == 9'd0) ? RESP : WAIT;
            cnt_q   <= lat_m1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (enter_resp) begin
        ready_q <= 1'b1;
        if (resp_wr) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
          rdata_q  <= ram_q[resp_idx];
        end
      end
    end
  end

  // Request payload is only meaningful while a request is in flight, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_q <= mem.mem_wr;
      idx_q   <= idx_d;
      wdata_q <= mem.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == RESP && op_wr_q) ram_q[idx_q] <= wdata_q;
  end

  assign mem.mem_rdata = rdata_q;
  assign mem.mem_ready = ready_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;
  assign rd_count_o    = rd_cnt_q;
  assign wr_count_o    = wr_cnt_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of single requests plus back-to-back and reset-mid-op sequences.
module tb_mem_responder;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DL  = 10;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic        err;
  logic [31:0] rdc;
  logic [31:0] wrc;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus.slave),
    .busy_o     (busy),
    .err_o      (err),
    .rd_count_o (rdc),
    .wr_count_o (wrc)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t        vt [12];
  int          checks = 0;
  int          failures = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one request, drop it during WAIT, and check latency, data, error and counters.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
    logic        got;
    int          lat;
    logic [31:0] rdata_seen;
    logic [31:0] rexp;
    got = 1'b0;
    lat = 0;
    rdata_seen = '0;
    bus.mem_rd    = rd;
    bus.mem_wr    = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    @(posedge clk);
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      if (bus.mem_ready) begin
        got = 1'b1;
        lat = i;
        rdata_seen = bus.mem_rdata;
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      if (wr) begin
        exp_wr++;
        rexp = last_rd;
      end else begin
        exp_rd++;
        rexp = exp_rdata;
        last_rd = exp_rdata;
      end
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_rdata"}, rdata_seen, rexp);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      @(negedge clk);
      chk({tag, "_ready_drop"}, {31'd0, bus.mem_ready}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rd_count"}, rdc, exp_rd);
      chk({tag, "_wr_count"}, wrc, exp_wr);
    end
  endtask

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int          k;
    int          prev;

    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;

    vt[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,          1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,          1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0,          1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, 32'h0,          1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          32'h2222_2222, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,          1'b0};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          32'hCAFE_F00D, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_5A5A, 32'h0,          1'b0};
    vt[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0000_5A5A, 1'b0};
    vt[10] = '{1'b1, 1'b1, 32'h0000_0042, 32'h0000_1234, 32'h0,          1'b1};
    vt[11] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          32'h0000_1234, 1'b1};

    // Reset and idle state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_rdc",   rdc, 32'd0);
    chk("rst_wrc",   wrc, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err,
             $sformatf("v%0d", i));
    end
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Back-to-back reads with rd held high, address advanced in each ready cycle
    b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4;          b2b_addr[2] = 32'h8;
    b2b_data[0] = 32'h5A5A; b2b_data[1] = 32'h2222_2222; b2b_data[2] = 32'h3333_3333;
    k = 0;
    prev = 0;
    bus.mem_rd = 1'b1;
    bus.mem_wr = 1'b0;
    bus.mem_addr = b2b_addr[0];
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        chk($sformatf("b2b%0d_rdata", k), bus.mem_rdata, b2b_data[k]);
        if (k > 0) chk($sformatf("b2b%0d_spacing", k), i - prev, LAT + 1);
        prev = i;
        k++;
        if (k < 3) bus.mem_addr = b2b_addr[k];
        else bus.mem_rd = 1'b0;
      end
    end
    if (k < 3) chk("b2b_timeout", k, 3);
    exp_rd += 3;
    last_rd = b2b_data[2];
    @(negedge clk);
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    chk("b2b_rdc", rdc, exp_rd);
    chk("b2b_wrc", wrc, exp_wr);

    // Reset while a write is in flight
    bus.mem_wr = 1'b1;
    bus.mem_addr = 32'h8;
    bus.mem_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    bus.mem_wr = 1'b0;
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_async", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_ready%0d", i), {31'd0, bus.mem_ready}, 32'd0);
    end
    chk("midrst_err",   {31'd0, err}, 32'd0);
    chk("midrst_rdc",   rdc, 32'd0);
    chk("midrst_wrc",   wrc, 32'd0);
    chk("midrst_rdata", bus.mem_rdata, 32'd0);
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    last_rd = 32'h0;
    @(negedge clk);
    chk("midrst_no_late_ready", {31'd0, bus.mem_ready}, 32'd0);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 32'h3333_3333, 1'b0, "postrst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
